// File: rtl/sdcard_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sdcard_arb
//  Purpose  : Two-requester round-robin arbiter in front of one sdcard phy.
//             Hands one 512-beat block command at a time to the phy, routes
//             the data beats between the phy and the owning requester, then
//             releases the phy.
//  Ports    : clk_i/rst_i          clock, asynchronous active-low reset
//             rN_cmd_*             requester N command FIFO (pop/dir/addr/empty)
//             rN_rx_* / rN_tx_*    requester N read-byte / write-byte FIFOs
//             rN_err_o             one-cycle pulse, requester N command rejected
//             rx_data_o            shared read byte (straight from the phy)
//             phy_cmd_* / phy_rx_* / phy_tx_*   phy-side FIFO view
//             blkcnt_i             card size in blocks
//             owner_o / busy_o     current owner / arbiter holds the phy
//  Options  : SDCARD_ARB_WRPROT_EN adds wrprot_i; when high, write commands
//             are rejected like out-of-range commands.
//  Revision : 1.0  initial release
// ============================================================================
module sdcard_arb #(
  parameter int ADDRBITSZ = 32,
  parameter int BLKSZ     = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef SDCARD_ARB_WRPROT_EN
  input  logic                 wrprot_i,
`endif
  // requester 0
  output logic                 r0_cmd_pop_o,
  input  logic                 r0_cmd_data_i,
  input  logic [ADDRBITSZ-1:0] r0_cmd_addr_i,
  input  logic                 r0_cmd_empty_i,
  output logic                 r0_rx_push_o,
  input  logic                 r0_rx_full_i,
  output logic                 r0_tx_pop_o,
  input  logic                 r0_tx_empty_i,
  input  logic [7:0]           r0_tx_data_i,
  output logic                 r0_err_o,
  // requester 1
  output logic                 r1_cmd_pop_o,
  input  logic                 r1_cmd_data_i,
  input  logic [ADDRBITSZ-1:0] r1_cmd_addr_i,
  input  logic                 r1_cmd_empty_i,
  output logic                 r1_rx_push_o,
  input  logic                 r1_rx_full_i,
  output logic                 r1_tx_pop_o,
  input  logic                 r1_tx_empty_i,
  input  logic [7:0]           r1_tx_data_i,
  output logic                 r1_err_o,
  // shared read byte
  output logic [7:0]           rx_data_o,
  // phy side
  input  logic                 phy_cmd_pop_i,
  output logic                 phy_cmd_data_o,
  output logic [ADDRBITSZ-1:0] phy_cmd_addr_o,
  output logic                 phy_cmd_empty_o,
  input  logic                 phy_rx_push_i,
  input  logic [7:0]           phy_rx_data_i,
  output logic                 phy_rx_full_o,
  input  logic                 phy_tx_pop_i,
  output logic [7:0]           phy_tx_data_o,
  output logic                 phy_tx_empty_o,
  input  logic [ADDRBITSZ-1:0] blkcnt_i,
  output logic                 owner_o,
  output logic                 busy_o
);

  localparam int              c_CW        = (BLKSZ > 1) ? $clog2(BLKSZ) : 1;
  localparam logic [c_CW-1:0] c_LAST_BEAT = c_CW'(BLKSZ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_GRANT = 2'd2,
    ST_XFER  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_rr_last;
  logic            r_dir;
  logic [c_CW-1:0] r_cntr;

  logic                 w_own_dir;
  logic [ADDRBITSZ-1:0] w_own_addr;
  logic                 w_wp;
  logic                 w_reject;
  logic                 w_chk_rej;
  logic                 w_cmd_pop;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_beat;

  // The owner's command stays at the head of its FIFO until popped, so the
  // phy-side command fields are a straight mux of the owner's FIFO head.
  assign w_own_dir  = r_owner ? r1_cmd_data_i : r0_cmd_data_i;
  assign w_own_addr = r_owner ? r1_cmd_addr_i : r0_cmd_addr_i;

`ifdef SDCARD_ARB_WRPROT_EN
  assign w_wp = wrprot_i & w_own_dir;
`else
  assign w_wp = 1'b0;
`endif

  assign w_reject  = (w_own_addr >= blkcnt_i) | w_wp;
  assign w_chk_rej = (r_state == ST_CHECK) & w_reject;
  // Rejected commands are dropped from the requester FIFO without the phy
  // ever seeing them; granted ones are popped together with the phy pop.
  assign w_cmd_pop = w_chk_rej | ((r_state == ST_GRANT) & phy_cmd_pop_i);

  // Only strobes matching the latched direction are forwarded and counted.
  assign w_rd   = (r_state == ST_XFER) & ~r_dir;
  assign w_wr   = (r_state == ST_XFER) &  r_dir;
  assign w_beat = (w_rd & phy_rx_push_i) | (w_wr & phy_tx_pop_i);

  assign r0_cmd_pop_o = w_cmd_pop & ~r_owner;
  assign r1_cmd_pop_o = w_cmd_pop &  r_owner;
  assign r0_err_o     = w_chk_rej & ~r_owner;
  assign r1_err_o     = w_chk_rej &  r_owner;
  assign r0_rx_push_o = w_rd & phy_rx_push_i & ~r_owner;
  assign r1_rx_push_o = w_rd & phy_rx_push_i &  r_owner;
  assign r0_tx_pop_o  = w_wr & phy_tx_pop_i  & ~r_owner;
  assign r1_tx_pop_o  = w_wr & phy_tx_pop_i  &  r_owner;

  assign rx_data_o       = phy_rx_data_i;
  assign phy_cmd_empty_o = (r_state != ST_GRANT);
  assign phy_cmd_data_o  = (r_state == ST_GRANT) & w_own_dir;
  assign phy_cmd_addr_o  = (r_state == ST_GRANT) ? w_own_addr : '0;
  assign phy_rx_full_o   = w_rd & (r_owner ? r1_rx_full_i : r0_rx_full_i);
  assign phy_tx_empty_o  = ~w_wr | (r_owner ? r1_tx_empty_i : r0_tx_empty_i);
  assign phy_tx_data_o   = w_wr ? (r_owner ? r1_tx_data_i : r0_tx_data_i) : 8'h00;

  assign owner_o = r_owner;
  assign busy_o  = (r_state == ST_GRANT) | (r_state == ST_XFER);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;   // requester 0 wins the first tie
      r_dir     <= 1'b0;
      r_cntr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r0_cmd_empty_i || !r1_cmd_empty_i) begin
            if (!r0_cmd_empty_i && !r1_cmd_empty_i)
              r_owner <= ~r_rr_last;
            else
              r_owner <= r0_cmd_empty_i;  // the single pending requester
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_reject) begin
            r_rr_last <= r_owner;
            r_state   <= ST_IDLE;
          end else begin
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (phy_cmd_pop_i) begin
            r_dir   <= w_own_dir;
            r_cntr  <= '0;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_beat) begin
            if (r_cntr == c_LAST_BEAT) begin
              r_rr_last <= r_owner;
              r_state   <= ST_IDLE;
            end else begin
              r_cntr <= r_cntr + c_CW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdcard_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sdcard_arb
//  Purpose  : Self-checking bench for sdcard_arb. Requester FIFOs and the phy
//             are modelled with queues and counters; the expected grant order
//             is derived from the round-robin rule over queued commands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdcard_arb;

  localparam int ADDRBITSZ = 32;
  localparam int BLKSZ     = 512;
`ifdef SDCARD_ARB_WRPROT_EN
  localparam bit c_WP = 1'b1;
`else
  localparam bit c_WP = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic wrprot_i;
  logic r0_cmd_pop_o, r0_cmd_data_i, r0_cmd_empty_i, r0_rx_push_o, r0_rx_full_i;
  logic r0_tx_pop_o, r0_tx_empty_i, r0_err_o;
  logic [ADDRBITSZ-1:0] r0_cmd_addr_i;
  logic [7:0] r0_tx_data_i;
  logic r1_cmd_pop_o, r1_cmd_data_i, r1_cmd_empty_i, r1_rx_push_o, r1_rx_full_i;
  logic r1_tx_pop_o, r1_tx_empty_i, r1_err_o;
  logic [ADDRBITSZ-1:0] r1_cmd_addr_i;
  logic [7:0] r1_tx_data_i;
  logic [7:0] rx_data_o;
  logic phy_cmd_pop_i, phy_cmd_data_o, phy_cmd_empty_o;
  logic [ADDRBITSZ-1:0] phy_cmd_addr_o;
  logic phy_rx_push_i, phy_rx_full_o, phy_tx_pop_i, phy_tx_empty_o;
  logic [7:0] phy_rx_data_i, phy_tx_data_o;
  logic [ADDRBITSZ-1:0] blkcnt_i;
  logic owner_o, busy_o;

  always #5 clk_i = ~clk_i;

  sdcard_arb #(.ADDRBITSZ(ADDRBITSZ), .BLKSZ(BLKSZ)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
`ifdef SDCARD_ARB_WRPROT_EN
    .wrprot_i(wrprot_i),
`endif
    .r0_cmd_pop_o(r0_cmd_pop_o), .r0_cmd_data_i(r0_cmd_data_i), .r0_cmd_addr_i(r0_cmd_addr_i),
    .r0_cmd_empty_i(r0_cmd_empty_i), .r0_rx_push_o(r0_rx_push_o), .r0_rx_full_i(r0_rx_full_i),
    .r0_tx_pop_o(r0_tx_pop_o), .r0_tx_empty_i(r0_tx_empty_i), .r0_tx_data_i(r0_tx_data_i),
    .r0_err_o(r0_err_o),
    .r1_cmd_pop_o(r1_cmd_pop_o), .r1_cmd_data_i(r1_cmd_data_i), .r1_cmd_addr_i(r1_cmd_addr_i),
    .r1_cmd_empty_i(r1_cmd_empty_i), .r1_rx_push_o(r1_rx_push_o), .r1_rx_full_i(r1_rx_full_i),
    .r1_tx_pop_o(r1_tx_pop_o), .r1_tx_empty_i(r1_tx_empty_i), .r1_tx_data_i(r1_tx_data_i),
    .r1_err_o(r1_err_o),
    .rx_data_o(rx_data_o),
    .phy_cmd_pop_i(phy_cmd_pop_i), .phy_cmd_data_o(phy_cmd_data_o), .phy_cmd_addr_o(phy_cmd_addr_o),
    .phy_cmd_empty_o(phy_cmd_empty_o), .phy_rx_push_i(phy_rx_push_i), .phy_rx_data_i(phy_rx_data_i),
    .phy_rx_full_o(phy_rx_full_o), .phy_tx_pop_i(phy_tx_pop_i), .phy_tx_data_o(phy_tx_data_o),
    .phy_tx_empty_o(phy_tx_empty_o), .blkcnt_i(blkcnt_i), .owner_o(owner_o), .busy_o(busy_o)
  );

  typedef struct packed { logic dir; logic [ADDRBITSZ-1:0] addr; } cmd_t;
  typedef struct packed { logic req; logic dir; logic [ADDRBITSZ-1:0] addr; } txn_t;

  cmd_t q0[$];
  cmd_t q1[$];
  txn_t exp_q[$];

  int   n_vec, n_err;
  logic m_last;                 // requester served last (round-robin memory)
  logic m_xfer, m_owner, m_dir; // phy-side view of the running transfer
  int   m_beats;
  bit   m_after;                // final beat happened in the previous cycle
  int   txcnt0, txcnt1;         // bytes consumed from each requester tx FIFO
  int   obs_rx0, obs_rx1, obs_tx0, obs_tx1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {r0_cmd_pop_o, r1_cmd_pop_o, r0_rx_push_o, r1_rx_push_o,
                          r0_tx_pop_o, r1_tx_pop_o, r0_err_o, r1_err_o, phy_cmd_data_o,
                          phy_cmd_empty_o, phy_rx_full_o, phy_tx_empty_o, owner_o, busy_o},
          14'b00000000_0101_00);
    check({tag, "_addr"}, phy_cmd_addr_o, 0);
    check({tag, "_txd"}, phy_tx_data_o, 0);
  endtask

  task automatic add_cmd(input bit req, input bit dir, input logic [ADDRBITSZ-1:0] addr);
    cmd_t c;
    c.dir = dir; c.addr = addr;
    if (req) q1.push_back(c); else q0.push_back(c);
  endtask

  // Expected service order: alternate when both have work, otherwise serve
  // whoever has work. Every command (rejected or not) counts as a turn.
  task automatic plan();
    cmd_t a[$]; cmd_t b[$]; txn_t t; logic pick;
    a = q0; b = q1;
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) pick = ~m_last;
      else pick = (a.size() == 0);
      if (pick) begin t = {1'b1, b[0]}; b.delete(0); end
      else      begin t = {1'b0, a[0]}; a.delete(0); end
      exp_q.push_back(t);
      m_last = pick;
    end
  endtask

  function automatic bit rejected(input txn_t t);
    return (t.addr >= blkcnt_i) || (c_WP && wrprot_i && t.dir);
  endfunction

  // One clock: drive inputs at posedge+1, check at posedge+3, advance.
  task automatic step();
    logic [1:0] e_push, e_pop;
    logic e_full, e_empty, own_full, own_empty, who;
    logic [7:0] e_txd;
    txn_t t;
    bit rej;
    r0_cmd_empty_i = (q0.size() == 0);
    r1_cmd_empty_i = (q1.size() == 0);
    if (q0.size() > 0) begin r0_cmd_addr_i = q0[0].addr; r0_cmd_data_i = q0[0].dir; end
    if (q1.size() > 0) begin r1_cmd_addr_i = q1[0].addr; r1_cmd_data_i = q1[0].dir; end
    r0_rx_full_i  = ($urandom_range(0, 3) == 0);
    r1_rx_full_i  = ($urandom_range(0, 3) == 0);
    r0_tx_empty_i = ($urandom_range(0, 3) == 0);
    r1_tx_empty_i = ($urandom_range(0, 3) == 0);
    r0_tx_data_i  = 8'h3C + 8'(txcnt0);
    r1_tx_data_i  = 8'hA5 + 8'(txcnt1);
    own_full  = m_owner ? r1_rx_full_i  : r0_rx_full_i;
    own_empty = m_owner ? r1_tx_empty_i : r0_tx_empty_i;
    phy_cmd_pop_i = 1'b0;
    if (m_xfer && !m_dir) begin
      phy_rx_push_i = !own_full && ($urandom_range(0, 3) != 0);
      phy_tx_pop_i  = ($urandom_range(0, 7) == 0);   // wrong-direction strobe
      phy_rx_data_i = 8'(m_beats);
    end else if (m_xfer) begin
      phy_tx_pop_i  = !own_empty && ($urandom_range(0, 3) != 0);
      phy_rx_push_i = ($urandom_range(0, 7) == 0);   // wrong-direction strobe
      phy_rx_data_i = 8'($urandom);
    end else begin
      phy_rx_push_i = ($urandom_range(0, 7) == 0);   // stray strobes
      phy_tx_pop_i  = ($urandom_range(0, 7) == 0);
      phy_rx_data_i = 8'($urandom);
      phy_cmd_pop_i = !phy_cmd_empty_o && ($urandom_range(0, 1) == 1);
    end
    #2;
    e_push = 2'b00; e_pop = 2'b00; e_full = 1'b0; e_empty = 1'b1; e_txd = 8'h00;
    if (m_xfer && !m_dir) begin e_push[m_owner] = phy_rx_push_i; e_full = own_full; end
    if (m_xfer && m_dir) begin
      e_pop[m_owner] = phy_tx_pop_i; e_empty = own_empty;
      e_txd = m_owner ? r1_tx_data_i : r0_tx_data_i;
    end
    check("rx_push", {r1_rx_push_o, r0_rx_push_o}, e_push);
    check("tx_pop", {r1_tx_pop_o, r0_tx_pop_o}, e_pop);
    check("phy_rx_full", phy_rx_full_o, e_full);
    check("phy_tx_empty", phy_tx_empty_o, e_empty);
    check("phy_tx_data", phy_tx_data_o, e_txd);
    check("rx_data", rx_data_o, phy_rx_data_i);
    check("err_without_pop", {r1_err_o & ~r1_cmd_pop_o, r0_err_o & ~r0_cmd_pop_o}, 0);
    check("dual_cmd_pop", r0_cmd_pop_o & r1_cmd_pop_o, 0);
    check("phy_pop_unanswered", phy_cmd_pop_i & ~(r0_cmd_pop_o | r1_cmd_pop_o), 0);
    if (m_xfer) begin
      check("busy_xfer", busy_o, 1);
      check("owner_xfer", owner_o, m_owner);
    end
    if (m_after) check("busy_after_last", busy_o, 0);
    obs_rx0 += int'(r0_rx_push_o); obs_rx1 += int'(r1_rx_push_o);
    obs_tx0 += int'(r0_tx_pop_o);  obs_tx1 += int'(r1_tx_pop_o);
    m_after = 0;
    if (m_xfer && ((!m_dir && phy_rx_push_i) || (m_dir && phy_tx_pop_i))) begin
      if (m_dir) begin if (m_owner) txcnt1++; else txcnt0++; end
      m_beats++;
      if (m_beats == BLKSZ) begin m_xfer = 0; m_after = 1; end
    end
    if (r0_cmd_pop_o || r1_cmd_pop_o) begin
      who = r1_cmd_pop_o;
      if (exp_q.size() == 0) begin
        check("unexpected_cmd_pop", 1, 0);
      end else begin
        t = exp_q.pop_front();
        check("grant_req", who, t.req);
        rej = rejected(t);
        check("err_pulse", who ? r1_err_o : r0_err_o, rej);
        if (rej) begin
          check("phy_idle_on_err", {phy_cmd_empty_o, phy_cmd_pop_i}, 2'b10);
        end else begin
          check("phy_cmd_addr", phy_cmd_addr_o, t.addr);
          check("phy_cmd_dir", phy_cmd_data_o, t.dir);
          check("pop_with_phy", phy_cmd_pop_i, 1);
          check("busy_grant", busy_o, 1);
          m_xfer = 1; m_owner = t.req; m_dir = t.dir; m_beats = 0;
        end
      end
      if (who) begin if (q1.size() > 0) q1.delete(0); end
      else     begin if (q0.size() > 0) q0.delete(0); end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run(input string name, input int budget);
    int cyc, s_rx0, s_rx1, s_tx0, s_tx1, e_rx0, e_rx1, e_tx0, e_tx1;
    plan();
    e_rx0 = 0; e_rx1 = 0; e_tx0 = 0; e_tx1 = 0;
    foreach (exp_q[i]) begin
      if (!rejected(exp_q[i])) begin
        case ({exp_q[i].req, exp_q[i].dir})
          2'b00: e_rx0 += BLKSZ;
          2'b10: e_rx1 += BLKSZ;
          2'b01: e_tx0 += BLKSZ;
          default: e_tx1 += BLKSZ;
        endcase
      end
    end
    s_rx0 = obs_rx0; s_rx1 = obs_rx1; s_tx0 = obs_tx0; s_tx1 = obs_tx1;
    cyc = 0;
    while ((exp_q.size() > 0 || m_xfer) && cyc < budget) begin step(); cyc++; end
    check({name, "_complete"}, (exp_q.size() == 0) && !m_xfer, 1);
    step(); step();
    check({name, "_rx0_count"}, obs_rx0 - s_rx0, e_rx0);
    check({name, "_rx1_count"}, obs_rx1 - s_rx1, e_rx1);
    check({name, "_tx0_count"}, obs_tx0 - s_tx0, e_tx0);
    check({name, "_tx1_count"}, obs_tx1 - s_tx1, e_tx1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, n;
    logic [ADDRBITSZ-1:0] bc;
    n_vec = 0; n_err = 0; m_last = 1'b1; m_xfer = 0; m_owner = 0; m_dir = 0;
    m_beats = 0; m_after = 0; txcnt0 = 0; txcnt1 = 0;
    obs_rx0 = 0; obs_rx1 = 0; obs_tx0 = 0; obs_tx1 = 0;
    rst_i = 1'b0; wrprot_i = 1'b0; blkcnt_i = 4096;
    r0_cmd_data_i = 0; r0_cmd_addr_i = 0; r0_cmd_empty_i = 0; r0_rx_full_i = 1;
    r0_tx_empty_i = 0; r0_tx_data_i = 8'h5A;
    r1_cmd_data_i = 1; r1_cmd_addr_i = 0; r1_cmd_empty_i = 0; r1_rx_full_i = 1;
    r1_tx_empty_i = 0; r1_tx_data_i = 8'h77;
    phy_cmd_pop_i = 1; phy_rx_push_i = 1; phy_tx_pop_i = 1; phy_rx_data_i = 0;
    repeat (3) @(posedge clk_i);
    #2;
    check_reset("reset");
    r0_cmd_empty_i = 1; r1_cmd_empty_i = 1;
    phy_cmd_pop_i = 0; phy_rx_push_i = 0; phy_tx_pop_i = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    step(); step();

    add_cmd(0, 0, 3);
    run("r0_read", 3000);

    add_cmd(0, 0, 100); add_cmd(0, 1, 101);
    add_cmd(1, 1, 200); add_cmd(1, 0, 201);
    run("rr_both", 12000);

    add_cmd(1, 1, 10);
    run("r1_write", 3000);

    add_cmd(0, 0, 4096);
    run("r0_oob", 50);
    add_cmd(1, 0, 4095);
    run("r1_last_block", 3000);
    add_cmd(0, 1, 32'hFFFF_FFFF);
    run("r0_oob_max", 50);

    for (int k = 0; k < 4; k++) begin
      bc = ADDRBITSZ'($urandom_range(1, 64));
      blkcnt_i = bc;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++)
        add_cmd(0, 1'($urandom_range(0, 1)), ADDRBITSZ'($urandom_range(0, 67)));
      n = $urandom_range(1, 2);
      for (int j = 0; j < n; j++)
        add_cmd(1, 1'($urandom_range(0, 1)), ADDRBITSZ'($urandom_range(0, 67)));
      run("random", 12000);
    end
    blkcnt_i = 4096;

    wrprot_i = 1'b1;
    add_cmd(1, 1, 5); add_cmd(1, 0, 6);
    run("wrprot", 6000);
    wrprot_i = 1'b0;

    // last served is requester 0 here, so only the reset restores r0 priority
    add_cmd(0, 0, 4096);
    run("pre_reset_oob", 50);
    add_cmd(0, 0, 7);
    plan();
    cyc = 0;
    while (!(m_xfer && m_beats >= 200) && cyc < 3000) begin step(); cyc++; end
    check("reached_beat200", m_beats, 200);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset("async_reset");
    q0.delete(); q1.delete(); exp_q.delete();
    m_xfer = 0; m_after = 0; m_last = 1'b1;
    r0_cmd_empty_i = 1; r1_cmd_empty_i = 1;
    phy_rx_push_i = 0; phy_tx_pop_i = 0; phy_cmd_pop_i = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    add_cmd(1, 0, 21); add_cmd(0, 0, 20);
    run("post_reset", 6000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
